// File: rtl/sync_fifo_over_under_detection.sv
// sync_fifo_over_under_detection
//   Synchronous FIFO queue with one-cycle overflow/underflow error pulses and
//   an occupancy count. All logic runs on the rising edge of clk. The reset is
//   synchronous and active-high.
//
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset; clears pointers, count and outputs
//   wr_en      - write request; pushes data_in at the tail
//   rd_en      - read request; pops the head word onto data_out
//   data_in    - write data
//   data_out   - last word read (registered, held across rejected reads)
//   data_valid - one-cycle pulse; data_out was updated by an accepted read
//   count      - number of stored entries, 0..DEPTH
//   full       - count == DEPTH
//   empty      - count == 0
//   overflow   - one-cycle pulse; a write was rejected
//   underflow  - one-cycle pulse; a read was rejected
module sync_fifo_over_under_detection #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [PTR_WIDTH:0]    count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic                  rd_accept;
  logic                  wr_accept;

  assign full  = (count == CNT_WIDTH'(DEPTH));
  assign empty = (count == '0);

  // A read only needs a stored word. A write on a full queue still goes
  // through when a read frees the head slot in the same cycle. On an empty
  // queue the read is rejected, so there is no write-to-read bypass.
  always_comb begin
    rd_accept = rd_en && !empty;
    wr_accept = wr_en && (!full || rd_accept);
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;

      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end else if (wr_en) begin
        overflow <= 1'b1;
      end

      if (rd_accept) begin
        data_out   <= mem[rd_ptr];
        data_valid <= 1'b1;
        rd_ptr     <= rd_ptr + PTR_WIDTH'(1);
      end else if (rd_en) begin
        underflow <= 1'b1;
      end

      if (wr_accept && !rd_accept) begin
        count <= count + CNT_WIDTH'(1);
      end else if (rd_accept && !wr_accept) begin
        count <= count - CNT_WIDTH'(1);
      end
    end
  end

endmodule
